// File: rtl/des_fp_stage.sv
// des_fp_stage: DES output stage. Undoes the round-16 swap, applies the final
// permutation (IP^-1), buffers results in a 2-entry FIFO, and counts deliveries.
// Latency: a block accepted at edge N is on out_data with out_valid=1 in cycle N+1.
// Backpressure: in_ready = (count < 2), which is a function of state only.
// Ports:
//   clk, rst                 - clock and synchronous active-high reset
//   in_valid/in_ready        - input handshake for L16, R16 and in_tag
//   L16, R16                 - round-16 halves, in_tag = sideband tag
//   out_valid/out_ready      - output handshake for out_data and out_tag
//   out_data                 - 64-bit result, bit 63 = FIPS bit 1
//   blk_cnt                  - count of delivered blocks, wraps
module des_fp_stage #(
  parameter int TAG_W = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      L16,
  input  logic [31:0]      R16,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] blk_cnt
);

  // FIPS 46-3 IP^-1 table. Entry i is the FIPS bit position (1..64) of the
  // preoutput that lands at output FIPS position i+1.
  localparam int FP_TAB [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  logic [63:0]      pre;
  logic [63:0]      fp_dat;
  logic [5:0]       src;

  logic [63:0]      mem_dat [2];
  logic [TAG_W-1:0] mem_tag [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  // Swapping the halves back is the undo of the last round's exchange.
  assign pre = {R16, L16};

  // FIPS position p maps to vector bit 64-p.
  always_comb begin
    fp_dat = '0;
    src    = '0;
    for (int i = 0; i < 64; i++) begin
      src                 = 6'(64 - FP_TAB[i]);
      fp_dat[6'(63 - i)] = pre[src];
    end
  end

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head entry is a register; the pointer only moves on a pop, so the
  // presented block stays put while the consumer stalls.
  assign out_data = mem_dat[rd_ptr];
  assign out_tag  = mem_tag[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      // Storage is cleared too so out_data/out_tag read zero after reset.
      for (int i = 0; i < 2; i++) begin
        mem_dat[i] <= '0;
        mem_tag[i] <= '0;
      end
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      blk_cnt <= '0;
    end else begin
      if (push) begin
        mem_dat[wr_ptr] <= fp_dat;
        mem_tag[wr_ptr] <= in_tag;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr  <= ~rd_ptr;
        blk_cnt <= blk_cnt + CNT_W'(1);
      end
      // Push and pop together at count 1 leave the occupancy unchanged.
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_des_fp_stage.sv
module tb_des_fp_stage;

  localparam int TAG_W = 2;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      L16;
  logic [31:0]      R16;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic [CNT_W-1:0] blk_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0]      sb_dat [$];
  logic [TAG_W-1:0] sb_tag [$];
  logic [CNT_W-1:0] exp_cnt = '0;

  logic             prev_stall = 1'b0;
  logic [63:0]      prev_dat;
  logic [TAG_W-1:0] prev_tag;

  des_fp_stage #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .L16       (L16),
    .R16       (R16),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .blk_cnt   (blk_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference final permutation, built as the inverse of the initial
  // permutation: IP(y) = pre, so pre bit j comes from y bit IP[j].
  function automatic logic [63:0] fp_model(input logic [31:0] l, input logic [31:0] r);
    logic [63:0] p;
    logic [63:0] y;
    int row, col, ipv;
    p = {r, l};
    y = '0;
    for (int j = 1; j <= 64; j++) begin
      row = (j - 1) / 8;
      col = (j - 1) % 8;
      ipv = ((row < 4) ? (58 + 2 * row) : (57 + 2 * (row - 4))) - 8 * col;
      y[64 - ipv] = p[64 - j];
    end
    return y;
  endfunction

  // Scoreboard monitor, sampled mid-cycle so the next edge's handshakes are settled.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      sb_dat.delete();
      sb_tag.delete();
      exp_cnt    = '0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_data", out_data, prev_dat);
        chk("hold_tag", 64'(out_tag), 64'(prev_tag));
      end
      if (in_valid && in_ready) begin
        sb_dat.push_back(fp_model(L16, R16));
        sb_tag.push_back(in_tag);
      end
      if (out_valid && out_ready) begin
        if (sb_dat.size() == 0) begin
          chk("spurious_out", 64'(out_valid), 64'd0);
        end else begin
          chk("sb_data", out_data, sb_dat.pop_front());
          chk("sb_tag", 64'(out_tag), 64'(sb_tag.pop_front()));
          chk("sb_cnt", 64'(blk_cnt), 64'(exp_cnt));
          exp_cnt = exp_cnt + 1'b1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_dat   = out_data;
      prev_tag   = out_tag;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] l, input logic [31:0] r,
                      input logic [TAG_W-1:0] t, output int waits);
    bit done;
    done     = 1'b0;
    waits    = 0;
    in_valid = 1'b1;
    L16      = l;
    R16      = r;
    in_tag   = t;
    for (int k = 0; k < 20 && !done; k++) begin
      if (in_ready) done = 1'b1;
      else waits++;
      tick();
    end
    if (!done) chk("send_timeout", 64'(done), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 40 && sb_dat.size() != 0; k++) tick();
    if (sb_dat.size() != 0) chk("drain_timeout", 64'(sb_dat.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [31:0] l, r;
    rst       = 1'b1;
    in_valid  = 1'b0;
    L16       = '0;
    R16       = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_blk_cnt", 64'(blk_cnt), 64'd0);

    // FIPS known-answer vector
    send(32'h43423234, 32'h0A4CD995, 2'd1, w);
    chk("kat_valid", 64'(out_valid), 64'd1);
    chk("kat_data", out_data, 64'h85E813540F0AB405);
    chk("kat_tag", 64'(out_tag), 64'd1);
    drain();
    chk("kat_cnt", 64'(blk_cnt), 64'd1);

    // IP round trip
    out_ready = 1'b0;
    send(32'hF0AAF0AA, 32'hCC00CCFF, 2'd2, w);
    chk("rt_data", out_data, 64'h0123456789ABCDEF);
    drain();

    // Backpressure: two fit, the third waits
    out_ready = 1'b0;
    send(32'h11111111, 32'hA5A5A5A5, 2'd1, w);
    send(32'h22222222, 32'h5A5A5A5A, 2'd2, w);
    chk("bp_full_rdy", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    L16      = 32'h33333333;
    R16      = 32'hDEADBEEF;
    in_tag   = 2'd3;
    tick();
    tick();
    chk("bp_still_full", 64'(in_ready), 64'd0);
    chk("bp_head", out_data, fp_model(32'h11111111, 32'hA5A5A5A5));
    out_ready = 1'b1;
    send(32'h33333333, 32'hDEADBEEF, 2'd3, w);
    drain();
    chk("bp_cnt", 64'(blk_cnt), 64'd5);

    // Reset while full
    out_ready = 1'b0;
    send(32'h0BADF00D, 32'h12345678, 2'd1, w);
    send(32'hCAFEBABE, 32'h87654321, 2'd2, w);
    chk("pre_rst_full", 64'(in_ready), 64'd0);
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    chk("mrst_blk_cnt", 64'(blk_cnt), 64'd0);
    chk("mrst_out_data", out_data, 64'd0);
    tick();
    tick();
    tick();
    chk("mrst_no_stale", 64'(out_valid), 64'd0);

    // Streaming at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      l = $urandom;
      r = $urandom;
      send(l, r, TAG_W'(i), w);
      chk("stream_rdy", 64'(w), 64'd0);
      chk("stream_valid", 64'(out_valid), 64'd1);
    end
    drain();
    chk("stream_cnt", 64'(blk_cnt), 64'd10);

    // Counter wrap (4-bit)
    for (int i = 0; i < 5; i++) begin
      l = $urandom;
      r = $urandom;
      send(l, r, TAG_W'(i), w);
    end
    drain();
    chk("wrap_15", 64'(blk_cnt), 64'd15);
    send(32'hFFFFFFFF, 32'h00000000, 2'd0, w);
    drain();
    chk("wrap_0", 64'(blk_cnt), 64'd0);
    send(32'h00000000, 32'hFFFFFFFF, 2'd3, w);
    drain();
    chk("wrap_1", 64'(blk_cnt), 64'd1);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/des_fp_stage.md
# des_fp_stage

Output end of the DES datapath, the counterpart of the initial-permutation input stage. It accepts the final round halves L16/R16 from the round engine and forms the preoutput R16‖L16 (the undo of the last-round swap). It applies the FIPS 46-3 final permutation (IP⁻¹), buffers results in a 2-entry FIFO, and presents them over a valid/ready handshake. A wrapping block counter and a tag pass-through let the 3DES sequencer track which stage and block each result belongs to.

## Interface
- TAG_W, 2: width of sideband tag carried with each block (3DES stage / enc-dec flag)
- CNT_W, 16: width of completed-block counter
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  L16/R16/in_tag valid
- in_ready  output  1  stage can accept a block this cycle
- L16  input  32  left half after round 16
- R16  input  32  right half after round 16
- in_tag  input  TAG_W  sideband tag, travels with the block
- out_valid  output  1  out_data/out_tag valid
- out_ready  input  1  downstream accepts
- out_data  output  64  ciphertext/plaintext block, bit 63 = FIPS bit 1
- out_tag  output  TAG_W  tag of the block on out_data
- blk_cnt  output  CNT_W  number of blocks delivered (out handshakes), wraps

## Operation
- Preoutput: pre = {R16, L16}, a 64-bit value with pre[63] = FIPS bit 1.
- FP: out bit at FIPS position i = pre bit at FIPS position FP[i].
  - FP is the FIPS 46-3 IP⁻¹ table, first row 40 8 48 16 56 24 64 32.
  - Required identity: FP(IP(x)) = x for every x.
  - Purely combinational before the FIFO write.
- FIFO: 2 entries of {data[63:0], tag}, with write pointer, read pointer and count (0..2).
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
- in_ready = (count < 2). It depends on state only, never on out_ready, so there is no combinational ready path.
- out_valid = (count > 0). out_data/out_tag come from the head entry and are driven from registers.
- Simultaneous push and pop:
  - count 1: push and pop both occur, count stays 1, new entry appears next cycle.
  - count 2: in_ready = 0, so only the pop occurs.
- Pointers are 1 bit and wrap 1→0.
- blk_cnt increments by 1 on each pop and wraps from 2^CNT_W−1 to 0.
- Stability: while out_valid && !out_ready, out_data/out_tag are held stable. in_valid may be withdrawn without penalty.

## Timing
- Latency: a block accepted at edge N appears with out_valid = 1 after edge N (visible in cycle N+1) when the FIFO was empty.
- Throughput: 1 block/cycle when out_ready is held high.
- Reset (rst = 1 at an edge):
  - count = 0, pointers = 0, blk_cnt = 0.
  - out_valid = 0, in_ready = 1, out_data = 0, out_tag = 0.
- Reset mid-operation discards all buffered blocks and ignores any push or pop in that cycle.
- Full: count = 2 → in_ready = 0. in_valid is ignored, with no overwrite.
- Empty: count = 0 → out_valid = 0. out_ready is ignored, and neither the count nor blk_cnt changes.

## Test plan
- FP vector: L16=43423234, R16=0A4CD995, tag=1 → one cycle later out_data=85E813540F0AB405, out_tag=1, out_valid=1; after pop, blk_cnt=1.
- IP round-trip: L16=F0AAF0AA, R16=CC00CCFF (halves of IP(0123456789ABCDEF) swapped) → out_data=0123456789ABCDEF.
- Backpressure: out_ready=0, push 3 distinct blocks.
  - in_ready drops after the 2nd push; the 3rd is held by the source.
  - out_data stays at block 1.
  - Raise out_ready: blocks emerge in order 1,2,3, one per cycle, tags intact.
- Streaming: out_ready=1, in_valid=1 for 10 cycles → 10 outputs on consecutive cycles, in_ready constantly 1, blk_cnt=10.
- Reset: rst mid-stream with count=2 → next cycle out_valid=0, in_ready=1, blk_cnt=0, out_data=0; no stale block emerges afterward.
- Wrap: CNT_W=4, deliver 17 blocks → blk_cnt reads 15 then 0 then 1.
